// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
//   state_t : transaction FSM states (IDLE -> ISSUE -> [WAIT] -> RESP)
//   owner_t : which requester owns the transaction in flight
//   BE_W    : byte-enable width for the default 32-bit data path
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority grant logic (data wins) with a starvation guard for fetch.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   if_valid  : fetch request pending
//   d_valid   : data request pending
//   idle      : arbiter FSM is in IDLE and may accept (already reset-gated)
//   grant_if  : fetch is the winner this cycle
//   grant_d   : data is the winner this cycle
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic d_valid,
  input  logic idle,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       force_if;

  // Once data has won STARVE_LIM times in a row over a waiting fetch,
  // fetch takes the next slot regardless of the data request.
  assign force_if = (starve_cnt_q == STARVE_LIM);
  assign grant_if = idle && if_valid && (!d_valid || force_if);
  assign grant_d  = idle && d_valid && !(if_valid && force_if);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    starve_cnt_d = starve_cnt_q;
    if (idle) begin
      if (!if_valid || grant_if) begin
        starve_cnt_d = '0;
      end else if (grant_d && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch
// port (read-only) and the data port (read/write). One transaction in flight.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req_valid/ready/addr          : fetch request handshake + word address
//   if_rsp_valid/data                : one-cycle fetch response
//   d_req_valid/ready/addr/we/wdata/be : data request handshake + payload
//   d_rsp_valid/data                 : one-cycle read data or write ack (data 0)
//   mem_en/write/addr/write_data/be  : memory command, driven only in ISSUE
//   mem_read_data                    : memory data, valid RD_LAT cycles after mem_en
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic                  d_req_we,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_be,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data,
  output logic                  mem_en,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_read_data
);

  // Index of the last WAIT cycle; RD_LAT is limited to 1..4.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            lat_q, lat_d;

  logic idle;
  logic grant_if;
  logic grant_d;

  // Gating with rst keeps every output at 0 while reset is asserted,
  // even in the cycle before the synchronous reset takes effect.
  assign idle = (state_q == IDLE) && !rst;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .idle     (idle),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: the payload/data registers are reset too, so the mem_* and rsp
    // outputs can never show stale values from a dropped transaction.
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        // Payload is sampled only here; requester changes after accept are ignored.
        if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = d_req_addr;
          we_d    = d_req_we;
          wdata_d = d_req_wdata;
          be_d    = d_req_be;
          rdata_d = '0;
          state_d = ISSUE;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_req_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          be_d    = '1;
          rdata_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          rdata_d = mem_read_data;
          lat_d   = '0;
          state_d = RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      RESP: begin
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    if_req_ready   = 1'b0;
    d_req_ready    = 1'b0;
    if_rsp_valid   = 1'b0;
    if_rsp_data    = '0;
    d_rsp_valid    = 1'b0;
    d_rsp_data     = '0;
    mem_en         = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_be         = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if_req_ready = grant_if;
          d_req_ready  = grant_d;
        end
        ISSUE: begin
          mem_en         = 1'b1;
          mem_write      = we_q;
          mem_addr       = addr_q;
          mem_write_data = wdata_q;
          mem_be         = be_q;
        end
        RESP: begin
          if (owner_q == OWN_D) begin
            d_rsp_valid = 1'b1;
            d_rsp_data  = rdata_q;
          end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1 (a) and one
// with RD_LAT=3 (b), each with its own small memory model. Inputs change on
// the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance a (RD_LAT=1) ----------------
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [29:0] if_req_addr;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [29:0] d_req_addr;
  logic [31:0] d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_be;
  logic        mem_en, mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic [3:0]  mem_be;

  // ---------------- instance b (RD_LAT=3) ----------------
  logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [29:0] b_if_req_addr;
  logic [31:0] b_if_rsp_data;
  logic        b_d_req_valid, b_d_req_ready, b_d_req_we, b_d_rsp_valid;
  logic [29:0] b_d_req_addr;
  logic [31:0] b_d_req_wdata, b_d_rsp_data;
  logic [3:0]  b_d_req_be;
  logic        b_mem_en, b_mem_write;
  logic [29:0] b_mem_addr;
  logic [31:0] b_mem_write_data, b_mem_read_data;
  logic [3:0]  b_mem_be;

  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_be(mem_be), .mem_read_data(mem_read_data)
  );

  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_req_addr(b_d_req_addr),
    .d_req_we(b_d_req_we), .d_req_wdata(b_d_req_wdata), .d_req_be(b_d_req_be),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
    .mem_en(b_mem_en), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_write_data(b_mem_write_data), .mem_be(b_mem_be), .mem_read_data(b_mem_read_data)
  );

  // ---------------- memory models ----------------
  // Read data appears RD_LAT cycles after the mem_en cycle; on all other
  // cycles the delay line carries a marker so a mistimed capture is visible.
  localparam logic [31:0] NO_DATA = 32'hBAD0_BAD0;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[6'h10] <= 32'h0050_0093;
      mem_a[6'h30] <= 32'h1111_2222;
      mem_a[6'h31] <= 32'h3333_4444;
      mem_b[6'h08] <= 32'hCAFE_F00D;
      mem_b[6'h10] <= 32'h0050_0093;
      mem_loaded   <= 1'b1;
    end else begin
      if (mem_en && mem_write)
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) mem_a[mem_addr[5:0]][8*k +: 8] <= mem_write_data[8*k +: 8];
      if (b_mem_en && b_mem_write)
        for (int k = 0; k < 4; k++)
          if (b_mem_be[k]) mem_b[b_mem_addr[5:0]][8*k +: 8] <= b_mem_write_data[8*k +: 8];
    end
    pipe_a    <= (mem_en && !mem_write) ? mem_a[mem_addr[5:0]] : NO_DATA;
    pipe_b[0] <= (b_mem_en && !b_mem_write) ? mem_b[b_mem_addr[5:0]] : NO_DATA;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign mem_read_data   = pipe_a;
  assign b_mem_read_data = pipe_b[2];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge (inputs may be changed right after).
  task automatic go();
    @(negedge clk);
  endtask

  // Let combinational outputs settle before checking.
  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, "_ctl"}, {26'h0, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                          mem_en, mem_write}, 32'h0);
    check({tag, "_dat"}, {31'h0, |{if_rsp_data, d_rsp_data, mem_addr, mem_write_data, mem_be}},
          32'h0);
  endtask

  initial begin
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0; d_req_be = '0;
    b_if_req_valid = 1'b0; b_if_req_addr = '0;
    b_d_req_valid = 1'b0; b_d_req_addr = '0; b_d_req_we = 1'b0; b_d_req_wdata = '0;
    b_d_req_be = '0;

    // Reset: outputs 0 even with a request pending.
    rst = 1'b1;
    go(); go();
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    settle();
    check_all_zero_a("rst_outs");
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    go(); rst = 1'b0; settle();
    check_all_zero_a("post_rst_idle");

    // 1. Lone fetch of 0x10, RD_LAT=1.
    go(); if_req_valid = 1'b1; if_req_addr = 30'h10; settle();
    check("t1_if_ready_T", {31'h0, if_req_ready}, 32'h1);
    check("t1_d_ready_T", {31'h0, d_req_ready}, 32'h0);
    go(); if_req_valid = 1'b0; if_req_addr = 30'h3FF; settle();
    check("t1_mem_en_T1", {31'h0, mem_en}, 32'h1);
    check("t1_mem_addr_T1", {2'b0, mem_addr}, 32'h10);
    check("t1_mem_wr_be_T1", {27'h0, mem_write, mem_be}, 32'h0F);
    go(); settle();
    check("t1_mem_en_T2", {31'h0, mem_en}, 32'h0);
    check("t1_rsp_T2", {30'h0, if_rsp_valid, d_rsp_valid}, 32'h0);
    go(); settle();
    check("t1_if_rsp_valid_T3", {31'h0, if_rsp_valid}, 32'h1);
    check("t1_if_rsp_data_T3", if_rsp_data, 32'h0050_0093);
    check("t1_d_rsp_valid_T3", {31'h0, d_rsp_valid}, 32'h0);
    go(); settle();
    check("t1_if_rsp_pulse", {31'h0, if_rsp_valid}, 32'h0);

    // 2. Data write 0x20 with be=0011, then read it back.
    d_req_valid = 1'b1; d_req_addr = 30'h20; d_req_we = 1'b1;
    d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'b0011; settle();
    check("t2_d_ready_T", {30'h0, if_req_ready, d_req_ready}, 32'h1);
    go(); d_req_valid = 1'b0; settle();
    check("t2_mem_ctl_T1", {27'h0, mem_en, mem_write, mem_be}, 32'h33);
    check("t2_mem_addr_T1", {2'b0, mem_addr}, 32'h20);
    check("t2_mem_wdata_T1", mem_write_data, 32'hDEAD_BEEF);
    go(); settle();
    check("t2_d_rsp_valid_T2", {31'h0, d_rsp_valid}, 32'h1);
    check("t2_d_rsp_data_T2", d_rsp_data, 32'h0);
    check("t2_mem_en_T2", {31'h0, mem_en}, 32'h0);
    go(); d_req_valid = 1'b1; d_req_we = 1'b0; d_req_wdata = 32'h0; d_req_be = 4'hF; settle();
    check("t2_rd_ready", {31'h0, d_req_ready}, 32'h1);
    go(); d_req_valid = 1'b0; settle();
    check("t2_rd_mem_write", {30'h0, mem_en, mem_write}, 32'h2);
    go(); settle();
    check("t2_rd_wait_rsp", {31'h0, d_rsp_valid}, 32'h0);
    go(); settle();
    check("t2_rd_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    check("t2_rd_rsp_data", d_rsp_data, 32'h0000_BEEF);

    // 3. Both requesters held valid: D,D,D,D,IF repeating.
    go();
    if_req_valid = 1'b1; if_req_addr = 30'h10;
    d_req_valid = 1'b1; d_req_addr = 30'h3E; d_req_we = 1'b1; d_req_wdata = 32'h0; d_req_be = 4'hF;
    for (int g = 0; g < 10; g++) begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
        settle();
        if (if_req_ready || d_req_ready) begin
          found = 1'b1;
          check($sformatf("t3_grant%0d_is_d", g), {31'h0, d_req_ready}, {31'h0, (g % 5) != 4});
          check($sformatf("t3_grant%0d_excl", g), {31'h0, if_req_ready & d_req_ready}, 32'h0);
        end
        go();
        if (found) break;
      end
      if (!found) check($sformatf("t3_grant%0d_timeout", g), 32'h0, 32'h1);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (6) go();

    // 4. RD_LAT=3 read of 0x08 on instance b, with a fetch waiting behind it.
    b_d_req_valid = 1'b1; b_d_req_addr = 30'h08; b_d_req_we = 1'b0; b_d_req_be = 4'hF;
    b_if_req_valid = 1'b1; b_if_req_addr = 30'h10; settle();
    check("t4_ready_T", {30'h0, b_if_req_ready, b_d_req_ready}, 32'h1);
    go(); b_d_req_valid = 1'b0; settle();
    check("t4_mem_en_T1", {31'h0, b_mem_en}, 32'h1);
    check("t4_mem_addr_T1", {2'b0, b_mem_addr}, 32'h08);
    check("t4_if_ready_T1", {31'h0, b_if_req_ready}, 32'h0);
    for (int w = 2; w <= 4; w++) begin
      go(); settle();
      check($sformatf("t4_wait_T%0d", w),
            {29'h0, b_mem_en, b_d_rsp_valid, b_if_req_ready}, 32'h0);
    end
    go(); settle();
    check("t4_rsp_valid_T5", {31'h0, b_d_rsp_valid}, 32'h1);
    check("t4_rsp_data_T5", b_d_rsp_data, 32'hCAFE_F00D);
    check("t4_if_ready_T5", {31'h0, b_if_req_ready}, 32'h0);
    go(); settle();
    check("t4_if_accept_T6", {30'h0, b_if_req_ready, b_d_rsp_valid}, 32'h2);
    go(); b_if_req_valid = 1'b0;
    repeat (4) go();
    settle();
    check("t4_if_rsp_valid", {31'h0, b_if_rsp_valid}, 32'h1);
    check("t4_if_rsp_data", b_if_rsp_data, 32'h0050_0093);

    // 5. Reset during WAIT drops the read.
    go(); d_req_valid = 1'b1; d_req_addr = 30'h30; d_req_we = 1'b0; settle();
    check("t5_ready_T", {31'h0, d_req_ready}, 32'h1);
    go(); d_req_valid = 1'b0;
    go(); rst = 1'b1; settle();
    check_all_zero_a("t5_in_rst");
    go(); rst = 1'b0; settle();
    check_all_zero_a("t5_after_rst");
    go(); settle();
    check("t5_no_rsp", {30'h0, d_rsp_valid, if_rsp_valid}, 32'h0);
    go(); if_req_valid = 1'b1; if_req_addr = 30'h10; settle();
    check("t5_fresh_ready", {31'h0, if_req_ready}, 32'h1);
    go(); if_req_valid = 1'b0;
    go(); go(); settle();
    check("t5_fresh_rsp", {if_rsp_valid, if_rsp_data[30:0]}, {1'b1, 31'h0050_0093});

    // 6. Payload changes after accept are ignored.
    go(); d_req_valid = 1'b1; d_req_addr = 30'h30; d_req_we = 1'b0; settle();
    check("t6_ready_T", {31'h0, d_req_ready}, 32'h1);
    go(); d_req_valid = 1'b0; d_req_addr = 30'h31; settle();
    check("t6_mem_addr_T1", {2'b0, mem_addr}, 32'h30);
    go(); go(); settle();
    check("t6_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    check("t6_rsp_data", d_rsp_data, 32'h1111_2222);

    go();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port (read-only) and the CPU data port (read/write).
- Sits between `cpu` and the memory model inside `system`, replacing the split instruction/data memory paths.
- Arbitration is fixed-priority (data wins) with a starvation guard for fetch.
- At most one transaction is in flight.

Parameters:
- ADDR_W, 30, word-address width; matches the 30-bit pc/mem_addr.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted when valid&&ready
- if_req_addr  in  ADDR_W  fetch word address
- if_rsp_valid  out  1  one-cycle pulse, fetch data valid
- if_rsp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted when valid&&ready
- d_req_addr  in  ADDR_W  data word address
- d_req_we  in  1  1=write, 0=read
- d_req_wdata  in  DATA_W  write data
- d_req_be  in  DATA_W/8  byte enables; ignored on reads
- d_rsp_valid  out  1  one-cycle pulse: read data valid, or write acknowledge
- d_rsp_data  out  DATA_W  read data; 0 on write ack
- mem_en  out  1  memory command strobe
- mem_write  out  1  write command
- mem_addr  out  ADDR_W  memory word address
- mem_write_data  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_read_data  in  DATA_W  valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset: all outputs 0; FSM=IDLE; starve_cnt=0; latency counter=0.
- rst wins over every other event.
- Reset mid-transaction drops the in-flight operation. No rsp_valid is produced for it.
- FSM states:
  - IDLE: ready asserted to the winner only; loser's ready=0; both 0 if no valid. Accept at cycle T latches addr/we/wdata/be/owner → ISSUE.
  - ISSUE (T+1): mem_en=1, mem_addr/mem_write/mem_write_data/mem_be driven from latched values. Write → RESP; read → WAIT.
  - Fetch in ISSUE: mem_write=0, mem_be=all ones.
  - WAIT: lasts exactly RD_LAT cycles (T+2..T+1+RD_LAT). mem_read_data is captured on the last WAIT cycle → RESP.
  - RESP: owner's rsp_valid=1 for one cycle with captured data (0 for write ack) → IDLE.
  - RESP timing: read at T+2+RD_LAT; write at T+2.
- Outside ISSUE: mem_en=0, mem_write=0, and the other mem_* outputs hold 0.
- Both ready=0 in ISSUE/WAIT/RESP.
- Next accept possible the cycle after RESP.
- Throughput:
  - read: one per RD_LAT+3 cycles
  - write: one per 3 cycles
- Arbitration in IDLE:
  - Default: data wins if d_req_valid.
  - Fetch wins when if_req_valid && (!d_req_valid || starve_cnt==STARVE_MAX).
- starve_cnt update:
  - +1 (saturating) on each data grant while if_req_valid=1.
  - Cleared on a fetch grant, or in any IDLE cycle with if_req_valid=0.
- Requester obligations: hold valid and payload stable until accepted. Payload is sampled only at the accept edge; later changes are ignored.
- Simultaneous valid with starve_cnt<STARVE_MAX: data granted, fetch ready=0.
- rsp ports carry no backpressure: the requester must accept a response in the cycle it is presented.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}
  - owner_t enum {OWN_IF, OWN_D}
  - localparam BE_W = DATA_W/8
- Sub-module mem_arb_prio:
  - Combinational grant logic plus the starve_cnt register.
  - Inputs: clk, rst, if_valid, d_valid, idle.
  - Outputs: grant_if, grant_d.

Test Plan:
1. Reset, then lone fetch of addr 0x10 with RD_LAT=1, memory preloaded 0x00500093 → if_req_ready=1 at T; mem_en=1, mem_addr=0x10 at T+1; if_rsp_valid=1, data=0x00500093 at T+3; d_rsp_valid stays 0.
2. Data write addr 0x20, wdata 0xDEADBEEF, be=4'b0011 → mem_write=1, mem_be=0011 at T+1; d_rsp_valid=1, d_rsp_data=0 at T+2; a subsequent read of 0x20 returns 0x0000BEEF (memory pre-zeroed).
3. if_req_valid and d_req_valid held high continuously, STARVE_MAX=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF…; no fetch waits more than 4 data grants.
4. RD_LAT=3 read of 0x08 → exactly 3 WAIT cycles; rsp_valid at T+5; mem_en is high only at T+1.
5. rst asserted during WAIT → next cycle all outputs 0 and FSM=IDLE; no rsp_valid; fresh request after deassert completes normally.
6. Payload changed after accept (addr 0x30 → 0x31 at T+1) → memory still sees 0x30.
